tnn_neuron_scheduler: RTL and testbench

Time-multiplexing sequencer for one approximate TNN neuron core, i.e. a combinational 6-operand, 3-bit-per-operand, 1-bit-output comparator. It streams N operand sets from a feature memory through the single neuron, one set per cycle, and packs the N decision bits into a result word. The result word is handed downstream with a valid/ready handshake. It sits between the layer feature buffer and the next layer's input register.

---
 rtl/tnn_sched_pkg.sv | 25 ++
 rtl/tnn_sched_if.sv | 40 ++++
 rtl/tnn_sched_pipe.sv | 92 +++++++++
 rtl/tnn_neuron_scheduler.sv | 141 ++++++++++++++
 tb/tb_tnn_neuron_scheduler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tnn_sched_pkg.sv
// Shared types and helpers for the TNN neuron scheduler: FSM state encoding,
// default operand geometry and width helpers used by the top, the pipe and the bus.
package tnn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    localparam int IN_W_DEF  = 3;
    localparam int N_OPS_DEF = 6;

    // Width of the packed operand bus (operand a in the LSBs, last operand in the MSBs).
    function automatic int op_bus_w(input int n_ops, input int in_w);
        return n_ops * in_w;
    endfunction

    // Index width able to count 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tnn_sched_if.sv
// Scheduler bus: run control, feature-memory read port, neuron core port and
// the downstream result handshake. master = scheduler side, slave = environment.
interface tnn_sched_if #(
    parameter int N_NEURONS = 8,
    parameter int IN_W      = tnn_sched_pkg::IN_W_DEF,
    parameter int N_OPS     = tnn_sched_pkg::N_OPS_DEF,
    parameter int ADDR_W    = 8
);
    import tnn_sched_pkg::*;

    localparam int OP_W = op_bus_w(N_OPS, IN_W);

    // run control
    logic                  start;
    logic                  abort;
    logic [ADDR_W-1:0]     base_addr;
    logic                  busy;
    // feature memory read port
    logic                  mem_rd;
    logic [ADDR_W-1:0]     mem_addr;
    logic [OP_W-1:0]       mem_rdata;
    // neuron core port
    logic [OP_W-1:0]       nrn_operands;
    logic                  nrn_out;
    // downstream result handshake
    logic [N_NEURONS-1:0]  result;
    logic                  result_valid;
    logic                  result_ready;

    modport master (
        input  start, abort, base_addr, mem_rdata, nrn_out, result_ready,
        output busy, mem_rd, mem_addr, nrn_operands, result, result_valid
    );

    modport slave (
        output start, abort, base_addr, mem_rdata, nrn_out, result_ready,
        input  busy, mem_rd, mem_addr, nrn_operands, result, result_valid
    );

endinterface

// File: rtl/tnn_sched_pipe.sv
// Operand pipeline for the scheduler: tracks an issued read, registers the
// returned operand set for the neuron core, then writes the neuron decision into
// the result word at wr_idx. Flush drops anything in flight but keeps result.
module tnn_sched_pipe
    import tnn_sched_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int OP_W      = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,       // run accepted: zero result and write index
    input  logic                 flush_i,     // cancel: drop in-flight valid bits
    input  logic                 rd_issue_i,  // memory read strobe active this cycle
    input  logic [OP_W-1:0]      rdata_i,     // memory data, one cycle after the strobe
    input  logic                 nrn_out_i,   // neuron decision for operands_o
    output logic [OP_W-1:0]      operands_o,
    output logic [N_NEURONS-1:0] result_o,
    output logic                 last_wr_o    // final operand set is written this cycle
);

    localparam int IDX_W = idx_w(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    logic                 rd_pend_q, rd_pend_d;
    logic                 op_vld_q,  op_vld_d;
    logic [OP_W-1:0]      op_q,      op_d;
    logic [IDX_W-1:0]     wr_idx_q,  wr_idx_d;
    logic [N_NEURONS-1:0] result_q,  result_d;

    // Next-state of the read-pending, operand and decision-write stages.
    always_comb begin
        rd_pend_d = rd_pend_q;
        op_vld_d  = op_vld_q;
        op_d      = op_q;
        wr_idx_d  = wr_idx_q;
        result_d  = result_q;
        if (flush_i) begin
            rd_pend_d = 1'b0;
            op_vld_d  = 1'b0;
        end else if (clr_i) begin
            rd_pend_d = 1'b0;
            op_vld_d  = 1'b0;
            wr_idx_d  = '0;
            result_d  = '0;
        end else begin
            rd_pend_d = rd_issue_i;
            op_vld_d  = rd_pend_q;
            if (rd_pend_q) begin
                op_d = rdata_i;
            end else begin
                op_d = op_q;
            end
            if (op_vld_q) begin
                result_d[wr_idx_q] = nrn_out_i;
                wr_idx_d           = wr_idx_q + IDX_W'(1);
            end else begin
                wr_idx_d = wr_idx_q;
            end
        end
    end

    // Pipeline registers; the operand register doubles as the neuron input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            op_vld_q  <= 1'b0;
            op_q      <= '0;
            wr_idx_q  <= '0;
            result_q  <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            op_vld_q  <= op_vld_d;
            op_q      <= op_d;
            wr_idx_q  <= wr_idx_d;
            result_q  <= result_d;
        end
    end

    // Completion flag for the FSM: the last decision lands at this edge.
    always_comb begin
        if (op_vld_q && !flush_i && !clr_i && (wr_idx_q == LAST_IDX)) begin
            last_wr_o = 1'b1;
        end else begin
            last_wr_o = 1'b0;
        end
    end

    assign operands_o = op_q;
    assign result_o   = result_q;

endmodule

// File: rtl/tnn_neuron_scheduler.sv
// Time-multiplexing sequencer for one TNN neuron core: streams N operand sets
// from feature memory through the neuron, one per cycle, packs the decisions into
// a result word and offers it downstream with valid/ready.
module tnn_neuron_scheduler
    import tnn_sched_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int IN_W      = IN_W_DEF,
    parameter int N_OPS     = N_OPS_DEF,
    parameter int ADDR_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    tnn_sched_if.master bus
);

    localparam int OP_W  = op_bus_w(N_OPS, IN_W);
    localparam int IDX_W = idx_w(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    sched_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 busy_q, busy_d;
    logic                 result_valid_q, result_valid_d;

    logic                 accept_s;
    logic                 flush_s;
    logic                 last_wr_s;
    logic [OP_W-1:0]      operands_s;
    logic [N_NEURONS-1:0] result_s;

    // FSM next state, read sequencing and registered status outputs.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rd_idx_d   = rd_idx_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        accept_s   = 1'b0;
        flush_s    = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            flush_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        accept_s   = 1'b1;
                        base_d     = bus.base_addr;
                        rd_idx_d   = '0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.base_addr;
                        state_d    = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (rd_idx_q == LAST_IDX) begin
                        mem_rd_d = 1'b0;
                        state_d  = ST_DRAIN;
                    end else begin
                        rd_idx_d   = rd_idx_q + IDX_W'(1);
                        mem_rd_d   = 1'b1;
                        // Address wraps modulo 2^ADDR_W by construction.
                        mem_addr_d = base_q + ADDR_W'(rd_idx_q + IDX_W'(1));
                        state_d    = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (last_wr_s) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    // start is deliberately ignored here, even alongside ready.
                    if (result_valid_q && bus.result_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d         = (state_d != ST_IDLE);
        result_valid_d = (state_d == ST_HOLD);
    end

    // State and output registers; outputs return to zero asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            rd_idx_q       <= '0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            rd_idx_q       <= rd_idx_d;
            mem_rd_q       <= mem_rd_d;
            mem_addr_q     <= mem_addr_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    tnn_sched_pipe #(
        .N_NEURONS (N_NEURONS),
        .OP_W      (OP_W)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (accept_s),
        .flush_i    (flush_s),
        .rd_issue_i (mem_rd_q),
        .rdata_i    (bus.mem_rdata),
        .nrn_out_i  (bus.nrn_out),
        .operands_o (operands_s),
        .result_o   (result_s),
        .last_wr_o  (last_wr_s)
    );

    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.nrn_operands = operands_s;
    assign bus.result       = result_s;

endmodule

// File: tb/tb_tnn_neuron_scheduler.sv
// Scoreboard bench for tnn_neuron_scheduler: stimulus pushes expected addresses
// and result words; a negedge monitor pops and compares as the DUT presents them.
module tb_tnn_neuron_scheduler;
    import tnn_sched_pkg::*;

    localparam int N      = 8;
    localparam int IN_W   = 3;
    localparam int N_OPS  = 6;
    localparam int ADDR_W = 8;
    localparam int OP_W   = N_OPS * IN_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [OP_W-1:0]   mem [256];
    logic [ADDR_W-1:0] addr_q[$];
    logic [N-1:0]      res_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tnn_sched_if #(.N_NEURONS(N), .IN_W(IN_W), .N_OPS(N_OPS), .ADDR_W(ADDR_W)) bus ();

    tnn_neuron_scheduler #(.N_NEURONS(N), .IN_W(IN_W), .N_OPS(N_OPS), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // neuron core stand-in: a+b+c > d+e+f
    function automatic logic neuron_core(input logic [OP_W-1:0] o);
        logic [4:0] p;
        logic [4:0] q;
        p = 5'(o[2:0])   + 5'(o[5:3])   + 5'(o[8:6]);
        q = 5'(o[11:9])  + 5'(o[14:12]) + 5'(o[17:15]);
        return p > q;
    endfunction

    assign bus.nrn_out = neuron_core(bus.nrn_operands);

    // synchronous-read feature memory
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // reference: decision for set i computed straight from memory contents
    function automatic logic [N-1:0] model_result(input logic [7:0] base);
        logic [N-1:0]    r;
        logic [OP_W-1:0] ops;
        int              diff;
        int              v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            ops  = mem[8'(int'(base) + i)];
            diff = 0;
            for (int j = 0; j < N_OPS; j++) begin
                v = int'((ops >> (IN_W * j)) & OP_W'(7));
                if (j < N_OPS / 2) diff += v;
                else               diff -= v;
            end
            r[i] = (diff > 0);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < N; i++) mem[8'(int'(base) + i)] = OP_W'($urandom);
    endtask

    // one run: abort_at = 0 means complete run, else abort driven in cycle T+abort_at
    task automatic do_run(input logic [7:0] base, input int abort_at, input int gap,
                          input bit poke_start, input logic [N-1:0] exp_in, input bit use_exp);
        int k;
        int n_rd;
        k = 0;
        while (bus.busy && k < 200) begin step(); k++; end
        if (bus.busy) fail_now("idle_timeout", 64'(bus.busy));
        n_rd = (abort_at == 0 || abort_at > N) ? N : abort_at;
        for (int i = 0; i < n_rd; i++) addr_q.push_back(8'(int'(base) + i));
        if (abort_at == 0) res_q.push_back(use_exp ? exp_in : model_result(base));
        bus.base_addr = base;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.base_addr = 8'($urandom);
        if (abort_at != 0) begin
            repeat (abort_at - 1) step();
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
            check("abort_busy", 64'(bus.busy), 64'd0);
            check("abort_mem_rd", 64'(bus.mem_rd), 64'd0);
            check("abort_valid", 64'(bus.result_valid), 64'd0);
        end else begin
            k = 0;
            while (!bus.result_valid && k < 100) begin step(); k++; end
            if (!bus.result_valid) begin
                check("valid_timeout", 64'(bus.result_valid), 64'd1);
                res_q.delete();
                addr_q.delete();
            end else begin
                for (int g = 0; g < gap; g++) begin
                    bus.start = poke_start;
                    step();
                end
                bus.start        = poke_start;
                bus.result_ready = 1'b1;
                step();
                bus.result_ready = 1'b0;
                bus.start        = 1'b0;
                check("hs_busy_low", 64'(bus.busy), 64'd0);
                check("hs_valid_low", 64'(bus.result_valid), 64'd0);
            end
        end
    endtask

    // monitor: pops expectations whenever the DUT reads memory or offers a result
    initial begin : monitor
        int                t_start;
        bit                prev_busy;
        bit                prev_valid;
        bit                seen_done;
        logic [ADDR_W-1:0] ea;
        t_start = 0; prev_busy = 1'b0; prev_valid = 1'b0; seen_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0; prev_valid = 1'b0; seen_done = 1'b0;
            end else begin
                if (bus.mem_rd) begin
                    if (addr_q.size() == 0) fail_now("unexpected_read", 64'(bus.mem_addr));
                    else begin
                        ea = addr_q.pop_front();
                        check("mem_addr", 64'(bus.mem_addr), 64'(ea));
                    end
                end
                if (bus.busy && !prev_busy) begin
                    if (seen_done) check("start_spacing_ge_n4", 64'((cyc - t_start) >= N + 4), 64'd1);
                    t_start   = cyc;
                    seen_done = 1'b0;
                end
                if (bus.result_valid) begin
                    if (res_q.size() == 0) fail_now("unexpected_valid", 64'(bus.result));
                    else begin
                        check("result", 64'(bus.result), 64'(res_q[0]));
                        if (!prev_valid) check("valid_latency", 64'(cyc - t_start), 64'(N + 2));
                        if (bus.result_ready) begin
                            void'(res_q.pop_front());
                            seen_done = 1'b1;
                        end
                    end
                end
                prev_busy  = bus.busy;
                prev_valid = bus.result_valid;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ab;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.base_addr = '0;
        bus.result_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_operands", 64'(bus.nrn_operands), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_valid", 64'(bus.result_valid), 64'd0);
        rst_n = 1'b1;
        step();

        // set i outputs i[0]: odd sets a=7 others 0, even sets all zero
        for (int i = 0; i < N; i++) mem[8'h10 + i] = (i % 2 == 1) ? OP_W'(7) : OP_W'(0);

        // reset in the middle of RUN (cycle T+6)
        for (int i = 0; i < 5; i++) addr_q.push_back(8'(8'h10 + i));
        bus.base_addr = 8'h10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        check("pre_rst_result_nonzero", 64'(bus.result != '0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check("midrst_valid", 64'(bus.result_valid), 64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        check("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // nominal: 8'hAA at base 0x10
        do_run(8'h10, 0, 0, 1'b0, 8'hAA, 1'b1);
        // address wrap
        fill(8'hFE);
        do_run(8'hFE, 0, 1, 1'b0, '0, 1'b0);
        // backpressure with start pulses during HOLD
        fill(8'h20);
        do_run(8'h20, 0, 20, 1'b1, '0, 1'b0);
        // abort in cycle T+4, then a full run
        fill(8'h30);
        do_run(8'h30, 4, 0, 1'b0, '0, 1'b0);
        do_run(8'h30, 0, 0, 1'b0, '0, 1'b0);

        // randomised runs
        for (int r = 0; r < 500; r++) begin
            logic [7:0] b;
            b = 8'($urandom);
            fill(b);
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, N + 2)) : 0;
            do_run(b, ab, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), '0, 1'b0);
        end

        repeat (5) step();
        check("res_q_drained", 64'(res_q.size()), 64'd0);
        check("addr_q_drained", 64'(addr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
